// File: rtl/demux_1to4_tdm.sv
// Registered 1-to-4 demultiplexer for a time-multiplexed receive stream.
// Each channel has a single-entry holding register with valid/ready backpressure.
module demux_1to4_tdm #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D_IN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             MODE,
   input  logic             S0,
   input  logic             S1,
   input  logic             frame_start,
   output logic [WIDTH-1:0] Y0,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Y3,
   output logic             Y0_valid,
   output logic             Y1_valid,
   output logic             Y2_valid,
   output logic             Y3_valid,
   input  logic             Y0_ready,
   input  logic             Y1_ready,
   input  logic             Y2_ready,
   input  logic             Y3_ready,
   output logic [1:0]       slot
);

   logic [3:0][WIDTH-1:0] y_data;
   logic [3:0]            y_valid;
   logic [3:0]            y_rdy;
   logic [1:0]            slot_q;
   logic [1:0]            tgt;
   logic                  accept;

   assign y_rdy = {Y3_ready, Y2_ready, Y1_ready, Y0_ready};

   // frame_start only resyncs the round-robin sequence; explicit mode ignores it
   always_comb begin
      tgt = {S1, S0};
      if (MODE) begin
         tgt = frame_start ? 2'd0 : slot_q;
      end
   end

   assign in_ready = !y_valid[tgt] || y_rdy[tgt];
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         y_data  <= '0;
         y_valid <= '0;
         slot_q  <= 2'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (accept && (tgt == 2'(k))) begin
               y_data[k]  <= D_IN;
               y_valid[k] <= 1'b1;
            end else if (y_valid[k] && y_rdy[k]) begin
               y_valid[k] <= 1'b0;
            end
         end
         if (accept && MODE) begin
            slot_q <= tgt + 2'd1;
         end
      end
   end

   assign Y0       = y_data[0];
   assign Y1       = y_data[1];
   assign Y2       = y_data[2];
   assign Y3       = y_data[3];
   assign Y0_valid = y_valid[0];
   assign Y1_valid = y_valid[1];
   assign Y2_valid = y_valid[2];
   assign Y3_valid = y_valid[3];
   assign slot     = slot_q;

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Self-checking bench for demux_1to4_tdm: directed beats with a scoreboard
// queue of {target, data} entries popped when the channel register updates.
module tb_demux_1to4_tdm;

   logic       clk;
   logic       rst;
   logic [7:0] D_IN;
   logic       in_valid;
   logic       in_ready;
   logic       MODE;
   logic       S0;
   logic       S1;
   logic       frame_start;
   logic [7:0] y0, y1, y2, y3;
   logic       v0, v1, v2, v3;
   logic [3:0] rdy;
   logic [1:0] slot;

   int tests_run = 0;
   int tests_failed = 0;
   logic [9:0] exp_q[$];

   demux_1to4_tdm #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .D_IN(D_IN), .in_valid(in_valid), .in_ready(in_ready),
      .MODE(MODE), .S0(S0), .S1(S1), .frame_start(frame_start),
      .Y0(y0), .Y1(y1), .Y2(y2), .Y3(y3),
      .Y0_valid(v0), .Y1_valid(v1), .Y2_valid(v2), .Y3_valid(v3),
      .Y0_ready(rdy[0]), .Y1_ready(rdy[1]), .Y2_ready(rdy[2]), .Y3_ready(rdy[3]),
      .slot(slot)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] get_y(input logic [1:0] k);
      case (k)
         2'd0:    return y0;
         2'd1:    return y1;
         2'd2:    return y2;
         default: return y3;
      endcase
   endfunction

   function automatic logic get_v(input logic [1:0] k);
      case (k)
         2'd0:    return v0;
         2'd1:    return v1;
         2'd2:    return v2;
         default: return v3;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_check(input string tag);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         chk({tag, "_qempty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_data"}, get_y(e[9:8]), e[7:0]);
         chk({tag, "_valid"}, get_v(e[9:8]), 1);
      end
   endtask

   // Drive one beat that must be accepted this cycle, then check where it landed.
   task automatic beat(input string tag, input logic [7:0] d, input logic mode,
                       input logic [1:0] sel, input logic fs,
                       input logic [1:0] exp_tgt, input logic [1:0] exp_slot);
      D_IN = d; in_valid = 1'b1; MODE = mode; {S1, S0} = sel; frame_start = fs;
      #1;
      chk({tag, "_in_ready"}, in_ready, 1);
      exp_q.push_back({exp_tgt, d});
      tick();
      in_valid = 1'b0; frame_start = 1'b0;
      pop_check(tag);
      chk({tag, "_slot"}, slot, exp_slot);
   endtask

   initial begin
      rst = 1'b1; D_IN = '0; in_valid = 1'b0; MODE = 1'b0; S0 = 1'b0; S1 = 1'b0;
      frame_start = 1'b0; rdy = 4'hF;
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_y", {y3, y2, y1, y0}, 0);
      chk("rst_valid", {v3, v2, v1, v0}, 0);
      chk("rst_slot", slot, 0);

      // explicit routing; each beat drains one cycle later since all ready=1
      beat("exp0", 8'hA0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0);
      beat("exp1", 8'hA1, 1'b0, 2'd1, 1'b0, 2'd1, 2'd0);
      chk("exp_drain0", v0, 0);
      beat("exp2", 8'hA2, 1'b0, 2'd2, 1'b0, 2'd2, 2'd0);
      chk("exp_drain1", v1, 0);
      beat("exp3", 8'hA3, 1'b0, 2'd3, 1'b0, 2'd3, 2'd0);
      chk("exp_drain2", v2, 0);
      tick();
      chk("exp_drain3", v3, 0);
      chk("exp_hold_y0", y0, 8'hA0);
      chk("exp_hold_y3", y3, 8'hA3);

      // round robin with wrap, slot advancing 1,2,3,0,1,2
      beat("rr0", 8'h10, 1'b1, 2'd3, 1'b0, 2'd0, 2'd1);
      beat("rr1", 8'h11, 1'b1, 2'd0, 1'b0, 2'd1, 2'd2);
      beat("rr2", 8'h12, 1'b1, 2'd0, 1'b0, 2'd2, 2'd3);
      beat("rr3", 8'h13, 1'b1, 2'd0, 1'b0, 2'd3, 2'd0);
      beat("rr4", 8'h14, 1'b1, 2'd0, 1'b0, 2'd0, 2'd1);
      beat("rr5", 8'h15, 1'b1, 2'd0, 1'b0, 2'd1, 2'd2);

      // backpressure on channel 2
      rdy = 4'b1011;
      beat("bp55", 8'h55, 1'b0, 2'd2, 1'b0, 2'd2, 2'd2);
      D_IN = 8'h66; in_valid = 1'b1; {S1, S0} = 2'd2;
      #1;
      chk("bp_stall_ready", in_ready, 0);
      tick();
      chk("bp_hold_y2", y2, 8'h55);
      chk("bp_hold_v2", v2, 1);
      beat("bp77", 8'h77, 1'b0, 2'd1, 1'b0, 2'd1, 2'd2);
      chk("bp_hold2_y2", y2, 8'h55);
      D_IN = 8'h66; in_valid = 1'b1; {S1, S0} = 2'd2;
      #1;
      chk("bp_stall2_ready", in_ready, 0);
      tick();
      chk("bp_hold3_v2", v2, 1);
      rdy = 4'hF;
      beat("bp66", 8'h66, 1'b0, 2'd2, 1'b0, 2'd2, 2'd2);
      tick();
      chk("bp_drain_v2", v2, 0);

      // frame_start without a beat is ignored; with a beat it resyncs to Y0
      MODE = 1'b1; frame_start = 1'b1; in_valid = 1'b0;
      tick();
      frame_start = 1'b0;
      chk("fs_idle_slot", slot, 2);
      beat("fs10", 8'h10, 1'b1, 2'd0, 1'b1, 2'd0, 2'd1);
      beat("fs11", 8'h11, 1'b1, 2'd0, 1'b0, 2'd1, 2'd2);
      beat("fs12", 8'h12, 1'b1, 2'd0, 1'b1, 2'd0, 2'd1);

      // build up held data on Y1/Y3 with slot=3, then reset mid-operation
      rdy = 4'b0101;
      beat("mid22", 8'h22, 1'b0, 2'd3, 1'b0, 2'd3, 2'd1);
      beat("mid20", 8'h20, 1'b1, 2'd0, 1'b0, 2'd1, 2'd2);
      beat("mid21", 8'h21, 1'b1, 2'd0, 1'b0, 2'd2, 2'd3);
      chk("mid_held", {v3, v1}, 2'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", {v3, v2, v1, v0}, 0);
      chk("mid_rst_y", {y3, y2, y1, y0}, 0);
      chk("mid_rst_slot", slot, 0);
      rdy = 4'hF;
      beat("mid30", 8'h30, 1'b1, 2'd3, 1'b0, 2'd0, 2'd1);

      // mode switch keeps slot
      beat("ms31", 8'h31, 1'b1, 2'd0, 1'b0, 2'd1, 2'd2);
      beat("ms99", 8'h99, 1'b0, 2'd3, 1'b1, 2'd3, 2'd2);
      beat("ms9a", 8'h9A, 1'b1, 2'd3, 1'b0, 2'd2, 2'd3);

      chk("q_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
